serial_add_ctrl: RTL and testbench

//  Bit-serial adder/subtractor controller. Accepts WIDTH-bit operands over a

---
 rtl/serial_add_ctrl_pkg.sv | 26 ++
 rtl/serial_add_ctrl_fulladd.sv | 24 ++
 rtl/serial_add_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial add/sub controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// State encoding is fixed so that waveforms and any external decode agree:
// IDLE=0, RUN=1, DONE=2. Encoding 3 is unused and recovers to IDLE.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Result bits gathered at the end of a RUN pass.
  typedef struct packed {
    logic c_out;
    logic ovf;
  } flags_t;

  // Carry injected at bit 0: subtraction is a + ~b + 1, so c_in is ignored.
  function automatic logic initial_carry(input logic op_sub, input logic c_in);
    return op_sub ? 1'b1 : c_in;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// One-bit full adder cell shared by the serial datapath.
// Latency: combinational, zero cycles.
// Backpressure: none (pure logic).
//
// Ports:
//   c_in  : carry in
//   a, b  : operand bits
//   s_out : sum bit
//   c_out : carry out
module fulladd (
  input  logic c_in,
  input  logic a,
  input  logic b,
  output logic s_out,
  output logic c_out
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s_out    = half_sum ^ c_in;
  assign c_out    = (a & b) | (c_in & half_sum);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor sequencer: one fulladd cell, LSB first.
// Latency: res_valid rises WIDTH cycles after the accepting edge.
// Backpressure: req_ready only in IDLE; result held in DONE until res_ready.
//
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake carrying a, b, c_in, op_sub
//   a, b                : WIDTH-bit operands
//   c_in                : carry in for add (ignored for subtract)
//   op_sub              : 0 = a+b+c_in, 1 = a-b
//   busy                : serial pass in progress
//   res_valid/res_ready : result handshake carrying sum, c_out, ovf
//   sum                 : WIDTH-bit result, modulo 2^WIDTH
//   c_out               : final carry (subtract: 1 = no borrow)
//   ovf                 : signed overflow
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  sum_sr_q, sum_sr_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  flags_t            flags_q, flags_d;

  logic              fa_s;
  logic              fa_c_out;

  // The single shared cell always looks at bit 0 of the shift registers.
  fulladd u_fulladd (
    .c_in  (carry_q),
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .s_out (fa_s),
    .c_out (fa_c_out)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        // Operands are captured only here; the request side is free after.
        if (req_valid) begin
          a_sr_d   = a;
          b_sr_d   = op_sub ? ~b : b;
          carry_d  = initial_carry(op_sub, c_in);
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_c_out;
        if (cnt_q == CNT_LAST) begin
          // On the MSB step carry_q is the carry into the MSB, so the
          // signed overflow is simply carry-in xor carry-out of that bit.
          flags_d.c_out = fa_c_out;
          flags_d.ovf   = carry_q ^ fa_c_out;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
    end
  end

  // Handshake outputs decode the registered state; data outputs are flops
  // and keep the last result through IDLE until the next accept.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign res_valid = (state_q == S_DONE);
  assign sum       = sum_sr_q;
  assign c_out     = flags_q.c_out;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 directed cases plus WIDTH=4 exhaustive.
// Inputs change 1 time unit after a rising edge; results are taken on the
// falling edge by per-instance monitors that pop an expected-result queue.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       req_valid8, req_ready8, c_in8, op_sub8, busy8;
  logic       res_valid8, res_ready8, c_out8, ovf8;
  logic [7:0] a8, b8, sum8;

  // WIDTH=4 instance
  logic       req_valid4, req_ready4, c_in4, op_sub4, busy4;
  logic       res_valid4, res_ready4, c_out4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid8), .req_ready(req_ready8),
    .a(a8), .b(b8), .c_in(c_in8), .op_sub(op_sub8),
    .busy(busy8),
    .res_valid(res_valid8), .res_ready(res_ready8),
    .sum(sum8), .c_out(c_out8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_ready(req_ready4),
    .a(a4), .b(b4), .c_in(c_in4), .op_sub(op_sub4),
    .busy(busy4),
    .res_valid(res_valid4), .res_ready(res_ready4),
    .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected {sum, c_out, ovf}
  logic [9:0] q8[$];
  logic [5:0] q4[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain wide addition, overflow from operand signs.
  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci, input logic sub);
    logic [3:0] bb;
    logic [4:0] t;
    logic       ov;
    bb = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {4'b0, (sub ? 1'b1 : ci)};
    ov = (a[3] == bb[3]) && (t[3] != a[3]);
    return {t[3:0], t[4], ov};
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid8 && res_ready8) begin
      if (q8.size() == 0) chk("spurious_res8", 32'(1), 32'(0));
      else                chk("res8", 32'({sum8, c_out8, ovf8}), 32'(q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && res_valid4 && res_ready4) begin
      if (q4.size() == 0) chk("spurious_res4", 32'(1), 32'(0));
      else                chk("res4", 32'({sum4, c_out4, ovf4}), 32'(q4.pop_front()));
    end
  end

  // Random consumer backpressure on the WIDTH=4 instance.
  initial begin
    res_ready4 = 1'b0;
    forever begin
      tick();
      res_ready4 = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present a request, wait (bounded) for acceptance, push its expectation.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sub, input logic [9:0] exp);
    int budget;
    a8 = a; b8 = b; c_in8 = ci; op_sub8 = sub; req_valid8 = 1'b1;
    budget = 0;
    while (!req_ready8 && budget < 100) begin
      tick();
      budget++;
    end
    if (!req_ready8) chk("timeout_req8", 32'(0), 32'(1));
    q8.push_back(exp);
    tick();
    req_valid8 = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       input logic sub);
    int budget;
    a4 = a; b4 = b; c_in4 = ci; op_sub4 = sub; req_valid4 = 1'b1;
    budget = 0;
    while (!req_ready4 && budget < 200) begin
      tick();
      budget++;
    end
    if (!req_ready4) chk("timeout_req4", 32'(0), 32'(1));
    q4.push_back(model4(a, b, ci, sub));
    tick();
    req_valid4 = 1'b0;
  endtask

  task automatic drain8;
    int budget;
    budget = 0;
    while (q8.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    if (q8.size() != 0) chk("timeout_res8", 32'(q8.size()), 32'(0));
  endtask

  task automatic drain4;
    int budget;
    budget = 0;
    while (q4.size() != 0 && budget < 2000) begin
      tick();
      budget++;
    end
    if (q4.size() != 0) chk("timeout_res4", 32'(q4.size()), 32'(0));
  endtask

  initial begin
    int lat, busyc, bad, nres;
    logic got;

    rst = 1'b1;
    req_valid8 = 1'b0; a8 = '0; b8 = '0; c_in8 = 1'b0; op_sub8 = 1'b0; res_ready8 = 1'b1;
    req_valid4 = 1'b0; a4 = '0; b4 = '0; c_in4 = 1'b0; op_sub4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // {req_ready, busy, res_valid, sum, c_out, ovf}
    chk("reset8", 32'({req_ready8, busy8, res_valid8, sum8, c_out8, ovf8}), 32'({3'b100, 8'h00, 2'b00}));
    chk("reset4", 32'({req_ready4, busy4, res_valid4, sum4, c_out4, ovf4}), 32'({3'b100, 4'h0, 2'b00}));
    rst = 1'b0;
    tick();

    // 1: 0x5A+0x3C with latency and busy-length check
    send8(8'h5A, 8'h3C, 1'b0, 1'b0, {8'h96, 1'b0, 1'b1});
    lat = 99; busyc = 0; got = 1'b0;
    for (int j = 0; j < 20 && !got; j++) begin
      @(negedge clk);
      if (res_valid8) begin
        got = 1'b1;
        lat = j;
      end else if (busy8) begin
        busyc++;
      end
    end
    chk("latency", 32'(lat), 32'(8));
    chk("busy_cycles", 32'(busyc), 32'(8));
    tick();
    drain8();

    // 2: add with carry in, wraps
    send8(8'hFF, 8'h01, 1'b1, 1'b0, {8'h01, 1'b1, 1'b0});
    drain8();

    // 3: subtracts (c_in driven high, must be ignored)
    send8(8'h10, 8'h20, 1'b1, 1'b1, {8'hF0, 1'b0, 1'b0});
    drain8();
    send8(8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1});
    drain8();

    // 4: consumer stall in DONE; a second request waits through RUN/DONE
    res_ready8 = 1'b0;
    send8(8'h12, 8'h34, 1'b0, 1'b0, {8'h46, 1'b0, 1'b0});
    a8 = 8'h80; b8 = 8'h80; c_in8 = 1'b0; op_sub8 = 1'b0; req_valid8 = 1'b1;
    bad = 0;
    for (int j = 0; j < 30 && !res_valid8; j++) begin
      if (req_ready8) bad++;
      tick();
    end
    chk("no_accept_in_run", 32'(bad), 32'(0));
    for (int h = 0; h < 5; h++) begin
      // {res_valid, sum, c_out, ovf, req_ready}
      chk("hold_done", 32'({res_valid8, sum8, c_out8, ovf8, req_ready8}),
          32'({1'b1, 8'h46, 1'b0, 1'b0, 1'b0}));
      tick();
    end
    res_ready8 = 1'b1;
    tick();
    chk("idle_ready", 32'(req_ready8), 32'(1));
    q8.push_back({8'h00, 1'b1, 1'b1});
    tick();
    req_valid8 = 1'b0;
    chk("accept_first_idle", 32'(busy8), 32'(1));
    drain8();

    // 5: reset in the third RUN cycle (c_out/ovf are 1 from the last op)
    send8(8'h55, 8'h00, 1'b0, 1'b0, {8'h55, 1'b0, 1'b0});
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_abort", 32'({req_ready8, busy8, res_valid8, sum8, c_out8, ovf8}),
        32'({3'b100, 8'h00, 2'b00}));
    q8.delete();
    tick();
    rst = 1'b0;
    nres = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (res_valid8) nres++;
    end
    chk("no_res_after_rst", 32'(nres), 32'(0));
    send8(8'h01, 8'h01, 1'b0, 1'b0, {8'h02, 1'b0, 1'b0});
    drain8();

    // 6: WIDTH=4 exhaustive against the model, random backpressure
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++)
            send4(4'(a), 4'(b), 1'(ci), 1'(s));
    drain4();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
